// File: rtl/pattern_pkg.sv
// Shared pattern codes and colour-formatting helpers for the pattern engine.
// Helpers return a wide vector; callers keep the low CW bits.
package pattern_pkg;

    localparam int MAX_CW = 48;

    localparam logic [4:0] PAT_SOLID        = 5'd0;
    localparam logic [4:0] PAT_CHECK_FIRST  = 5'd1;
    localparam logic [4:0] PAT_CHECK_LAST   = 5'd7;
    localparam logic [4:0] PAT_GRID_FIRST   = 5'd8;
    localparam logic [4:0] PAT_GRID_LAST    = 5'd11;
    localparam logic [4:0] PAT_BLOCK_FIRST  = 5'd12;
    localparam logic [4:0] PAT_BLOCK_LAST   = 5'd18;
    localparam logic [4:0] PAT_SUM_FIRST    = 5'd19;
    localparam logic [4:0] PAT_SUM_LAST     = 5'd21;
    localparam logic [4:0] PAT_DIFF_FIRST   = 5'd22;
    localparam logic [4:0] PAT_DIFF_LAST    = 5'd24;
    localparam logic [4:0] PAT_PROD_FIRST   = 5'd25;
    localparam logic [4:0] PAT_PROD_LAST    = 5'd27;
    localparam logic [4:0] PAT_VBAR_DARK    = 5'd28;
    localparam logic [4:0] PAT_VBAR_BRIGHT  = 5'd29;
    localparam logic [4:0] PAT_HBAR_DARK    = 5'd30;
    localparam logic [4:0] PAT_HBAR_BRIGHT  = 5'd31;

    // {R,G,B} 2-bit fields, each repeated MSB-first across its CW/3-bit channel.
    function automatic logic [MAX_CW-1:0] expand6(input logic [5:0] v, input int cw);
        logic [MAX_CW-1:0] c;
        logic [1:0] f;
        int n, ch, j;
        c = '0;
        n = cw / 3;
        for (int i = 0; i < MAX_CW; i++) begin
            if (i < cw) begin
                ch = i / n;
                j  = (n - 1) - (i % n);
                f  = v[2*ch +: 2];
                c[i] = (j % 2 == 0) ? f[1] : f[0];
            end
        end
        return c;
    endfunction

    function automatic logic [MAX_CW-1:0] bar_color(input logic [2:0] b, input logic bright,
                                                     input int cw);
        logic [MAX_CW-1:0] c;
        logic bit_r, bit_g, bit_b, chv;
        int n, ch, j;
        c = '0;
        n = cw / 3;
        bit_r = ~b[1];
        bit_g = ~b[2];
        bit_b = ~b[0];
        for (int i = 0; i < MAX_CW; i++) begin
            if (i < cw) begin
                ch  = i / n;
                j   = i % n;
                chv = (ch == 2) ? bit_r : ((ch == 1) ? bit_g : bit_b);
                c[i] = (bright || (j == n - 1)) ? chv : 1'b0;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/pattern_engine_if.sv
// Pixel-stream bundle between the timing core, the pattern engine and the DAC.
// No backpressure: every input is taken each clock; de_out qualifies color_out.
interface pattern_engine_if #(
    parameter int CW = 6,
    parameter int PW = 12
);
    logic [PW-1:0] hsize;
    logic [PW-1:0] vsize;
    logic [PW-1:0] hpos;
    logic [PW-1:0] vpos;
    logic          active;
    logic          frame_start;
    logic          anim_en;
    logic [4:0]    pattern;
    logic [CW-1:0] color_in;
    logic [CW-1:0] color_out;
    logic          de_out;

    modport master (
        output hsize, vsize, hpos, vpos, active, frame_start, anim_en, pattern, color_in,
        input  color_out, de_out
    );

    modport slave (
        input  hsize, vsize, hpos, vpos, active, frame_start, anim_en, pattern, color_in,
        output color_out, de_out
    );
endinterface

// File: rtl/bar_stepper.sv
// Divider-free floor(7*n/size) tracker: r += 7 per step, carry into q (saturating at 6).
// q is the current value, forced to 0 while restart is high.
module bar_stepper #(
    parameter int PW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart,
    input  logic          step,
    input  logic [PW-1:0] size,
    output logic [2:0]    q
);
    logic [2:0]    q_r, q_cur, q_nxt;
    logic [PW-1:0] r_r, r_cur, r_nxt;
    logic [PW:0]   r_add;

    always_comb begin
        q_cur = restart ? 3'd0 : q_r;
        r_cur = restart ? '0 : r_r;
        r_add = {1'b0, r_cur} + (PW+1)'(7);
        q_nxt = q_cur;
        r_nxt = r_add[PW-1:0];
        if (r_add >= {1'b0, size}) begin
            r_nxt = PW'(r_add - {1'b0, size});
            q_nxt = (q_cur == 3'd6) ? 3'd6 : q_cur + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= 3'd0;
            r_r <= '0;
        end else if (step) begin
            q_r <= q_nxt;
            r_r <= r_nxt;
        end
    end

    assign q = q_cur;
endmodule

// File: rtl/pattern_engine.sv
// Two-stage test-pattern generator: stage 1 registers scrolled coordinates and bar
// indices, stage 2 forms the colour and blanks it outside the active area.
module pattern_engine
    import pattern_pkg::*;
#(
    parameter int CW = 6,
    parameter int PW = 12,
    parameter int FW = 8
) (
    input logic              clk,
    input logic              rst,
    pattern_engine_if.slave  bus
);
    logic [FW-1:0] fcnt;
    logic          line_start;
    logic [2:0]    hq, vq, vb_line, vb_cur;

    logic          act_s1;
    logic [PW-1:0] hp_s1, vp_s1, m;
    logic [4:0]    pat_s1;
    logic [CW-1:0] c_s1, pix;
    logic [2:0]    hb_s1, vb_s1;
    logic [5:0]    v6;
    logic          use6;

    always_ff @(posedge clk) begin
        if (rst || !bus.anim_en) fcnt <= '0;
        else if (bus.frame_start) fcnt <= fcnt + 1'b1;
    end

    assign line_start = bus.active && (bus.hpos == '0);

    bar_stepper #(.PW(PW)) u_hstep (
        .clk(clk), .rst(rst), .restart(line_start), .step(bus.active),
        .size(bus.hsize), .q(hq)
    );

    bar_stepper #(.PW(PW)) u_vstep (
        .clk(clk), .rst(rst), .restart(bus.vpos == '0), .step(line_start),
        .size(bus.vsize), .q(vq)
    );

    // The vertical index is sampled at the first pixel and held for the whole line.
    always_ff @(posedge clk) begin
        if (rst) vb_line <= 3'd0;
        else if (line_start) vb_line <= vq;
    end
    assign vb_cur = line_start ? vq : vb_line;

    always_ff @(posedge clk) begin
        if (rst) begin
            act_s1 <= 1'b0;
            hp_s1  <= '0;
            vp_s1  <= '0;
            pat_s1 <= 5'd0;
            c_s1   <= '0;
            hb_s1  <= 3'd0;
            vb_s1  <= 3'd0;
        end else begin
            act_s1 <= bus.active;
            hp_s1  <= bus.hpos + PW'(fcnt);
            vp_s1  <= bus.vpos + PW'(fcnt);
            pat_s1 <= bus.pattern;
            c_s1   <= bus.color_in;
            hb_s1  <= (bus.hsize < PW'(8)) ? 3'd0 : hq;
            vb_s1  <= (bus.vsize < PW'(8)) ? 3'd0 : vb_cur;
        end
    end

    always_comb begin
        pix  = c_s1;
        v6   = 6'd0;
        use6 = 1'b0;
        m    = '0;
        if (pat_s1 == PAT_SOLID) begin
            pix = c_s1;
        end else if (pat_s1 <= PAT_CHECK_LAST) begin
            pix = (1'(hp_s1 >> (pat_s1 - PAT_CHECK_FIRST)) ^ 1'(vp_s1 >> (pat_s1 - PAT_CHECK_FIRST)))
                  ? ~c_s1 : c_s1;
        end else if (pat_s1 <= PAT_GRID_LAST) begin
            // Cell size 2^(p-5): codes 8..11 give 8..64 pixels.
            m   = (PW'(1) << (pat_s1 - PAT_GRID_FIRST + 5'd3)) - PW'(1);
            pix = (((hp_s1 & m) == '0) || ((hp_s1 & m) == m) ||
                   ((vp_s1 & m) == '0) || ((vp_s1 & m) == m)) ? ~c_s1 : c_s1;
        end else if (pat_s1 <= PAT_BLOCK_LAST) begin
            v6   = {1'(vp_s1 >> (pat_s1 - PAT_BLOCK_FIRST + 5'd2)),
                    1'(hp_s1 >> (pat_s1 - PAT_BLOCK_FIRST + 5'd2)),
                    2'(vp_s1 >> (pat_s1 - PAT_BLOCK_FIRST)),
                    2'(hp_s1 >> (pat_s1 - PAT_BLOCK_FIRST))};
            use6 = 1'b1;
        end else if (pat_s1 <= PAT_SUM_LAST) begin
            v6   = 6'((hp_s1 + vp_s1) >> (pat_s1 - PAT_SUM_FIRST));
            use6 = 1'b1;
        end else if (pat_s1 <= PAT_DIFF_LAST) begin
            v6   = 6'((hp_s1 - vp_s1) >> (pat_s1 - PAT_DIFF_FIRST));
            use6 = 1'b1;
        end else if (pat_s1 <= PAT_PROD_LAST) begin
            v6   = 6'((hp_s1 * vp_s1) >> (pat_s1 - PAT_PROD_FIRST));
            use6 = 1'b1;
        end else begin
            pix = CW'(bar_color(pat_s1[1] ? hb_s1 : vb_s1, pat_s1[0], CW));
        end
        if (use6) pix = CW'(expand6(v6, CW));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.color_out <= '0;
            bus.de_out    <= 1'b0;
        end else begin
            bus.color_out <= act_s1 ? pix : '0;
            bus.de_out    <= act_s1;
        end
    end
endmodule

// File: tb/tb_pattern_engine.sv
// Directed raster sequences with randomized pattern/colour, checked against a
// positional reference model through a two-deep expected queue.
module tb_pattern_engine;

    typedef struct {
        logic [5:0]  col;
        logic        de;
        logic        chk;
        logic [11:0] c12;
        logic        chk12;
        int          h;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pattern_engine_if #(.CW(6),  .PW(12)) bus();
    pattern_engine_if #(.CW(12), .PW(12)) bus12();

    pattern_engine #(.CW(6),  .PW(12), .FW(8)) u_dut   (.clk(clk), .rst(rst), .bus(bus));
    pattern_engine #(.CW(12), .PW(12), .FW(8)) u_dut12 (.clk(clk), .rst(rst), .bus(bus12));

    exp_t        exp_q[$];
    int          n_asrt = 0;
    int          n_fail = 0;
    int          m_f = 0;
    int          hsz = 640;
    int          vsz = 480;
    logic        anim = 1'b0;
    logic        hb_ok = 1'b0;
    logic        vb_ok = 1'b0;
    logic        chk12_next = 1'b0;
    logic [11:0] exp12_next = 12'h0;
    logic [5:0]  line_cap [1024];
    logic [5:0]  bright_tab [7] = '{6'h3F, 6'h3C, 6'h0F, 6'h0C, 6'h33, 6'h30, 6'h03};
    int          cap_pos [14] = '{0, 91, 92, 182, 183, 274, 275, 365, 366, 457, 458, 548, 549, 639};
    int          cap_idx [14] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6};

    function automatic int bar_idx(input int pos, input int sz);
        int q;
        if (sz < 8) return 0;
        q = (7 * pos) / sz;
        return (q > 6) ? 6 : q;
    endfunction

    function automatic logic [5:0] model(input int p, input logic [5:0] c, input int h, input int v,
                                         input int f, input int hs, input int vs);
        int hp, vp, k, m, idx;
        hp = (h + f) % 4096;
        vp = (v + f) % 4096;
        if (p == 0) return c;
        if (p <= 7) return (((hp >> (p - 1)) ^ (vp >> (p - 1))) & 1) != 0 ? ~c : c;
        if (p <= 11) begin
            m = (1 << (p - 5)) - 1;
            return ((hp & m) == 0 || (hp & m) == m || (vp & m) == 0 || (vp & m) == m) ? ~c : c;
        end
        if (p <= 18) begin
            k = p - 12;
            return 6'((((vp >> (k + 2)) & 1) << 5) | (((hp >> (k + 2)) & 1) << 4) |
                      (((vp >> k) & 3) << 2) | ((hp >> k) & 3));
        end
        if (p <= 21) return 6'(((hp + vp) >> (p - 19)) & 63);
        if (p <= 24) return 6'((((hp - vp) & 4095) >> (p - 22)) & 63);
        if (p <= 27) return 6'(((hp * vp) >> (p - 25)) & 63);
        idx = (p >= 30) ? bar_idx(h, hs) : bar_idx(v, vs);
        return (p % 2 == 1) ? bright_tab[idx] : (bright_tab[idx] & 6'h2A);
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic a, input int h, input int v, input logic fs, input int p,
                        input logic [5:0] c);
        exp_t o, e;
        logic is_bar;
        @(negedge clk);
        if (exp_q.size() == 2) begin
            o = exp_q.pop_front();
            check("de_out", 12'(bus.de_out), 12'(o.de));
            if (o.chk) check("color_out", 12'(bus.color_out), 12'(o.col));
            if (o.chk12) check("color_out_cw12", bus12.color_out, o.c12);
            if (o.de) line_cap[o.h] = bus.color_out;
        end
        bus.active = a;       bus12.active = a;
        bus.hpos = 12'(h);    bus12.hpos = 12'(h);
        bus.vpos = 12'(v);    bus12.vpos = 12'(v);
        bus.frame_start = fs; bus12.frame_start = fs;
        bus.pattern = 5'(p);  bus12.pattern = 5'(p);
        bus.color_in = c;     bus12.color_in = {c, c};
        bus.anim_en = anim;   bus12.anim_en = anim;
        bus.hsize = 12'(hsz); bus12.hsize = 12'(hsz);
        bus.vsize = 12'(vsz); bus12.vsize = 12'(vsz);
        if (a && h == 0) begin
            hb_ok = 1'b1;
            if (v == 0) vb_ok = 1'b1;
        end
        is_bar = (p >= 28);
        e.de    = a;
        e.h     = h;
        e.col   = a ? model(p, c, h, v, m_f, hsz, vsz) : 6'h0;
        e.chk   = !(a && is_bar && !((p >= 30) ? hb_ok : vb_ok));
        e.c12   = exp12_next;
        e.chk12 = chk12_next;
        chk12_next = 1'b0;
        exp_q.push_back(e);
        m_f = anim ? (fs ? (m_f + 1) % 256 : m_f) : 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.active = 1'b0;      bus12.active = 1'b0;
        bus.frame_start = 1'b0; bus12.frame_start = 1'b0;
        exp_q.delete();
        m_f = 0;
        hb_ok = 1'b0;
        vb_ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_color_out", 12'(bus.color_out), 12'h0);
            check("rst_de_out", 12'(bus.de_out), 12'h0);
        end
        rst = 1'b0;
    endtask

    // pm: 0..31 fixed pattern, 32 any random pattern, 33 random bar pattern.
    task automatic frame(input int hs, input int vs, input int lines, input int hbl, input int pm,
                         input int cf, input logic fs_act, input int rl, input int rp);
        int p;
        logic [5:0] c;
        logic fs;
        hsz = hs;
        vsz = vs;
        tick(1'b0, 0, 0, 1'b1, 0, 6'h0);
        for (int v = 0; v < lines; v++) begin
            for (int h = 0; h < hs; h++) begin
                if (v == rl && h == rp) begin
                    do_reset();
                    break;
                end
                p  = (pm < 32) ? pm : ((pm == 32) ? int'($urandom_range(0, 31)) : int'($urandom_range(28, 31)));
                c  = (cf >= 0) ? 6'(cf) : 6'($urandom_range(0, 63));
                fs = fs_act && ($urandom_range(0, 31) == 0);
                tick(1'b1, h, v, fs, p, c);
            end
            for (int b = 0; b < hbl; b++) tick(1'b0, 0, v, 1'b0, 0, 6'h0);
        end
    endtask

    task automatic dir12(input int h, input int p, input logic [5:0] c, input logic [11:0] exp);
        exp12_next = exp;
        chk12_next = 1'b1;
        tick(1'b1, h, 0, 1'b0, p, c);
    endtask

    initial begin
        bus.active = 1'b0; bus.frame_start = 1'b0; bus.anim_en = 1'b0; bus.pattern = 5'd0;
        bus.hpos = '0; bus.vpos = '0; bus.hsize = 12'd640; bus.vsize = 12'd480; bus.color_in = '0;
        bus12.active = 1'b0; bus12.frame_start = 1'b0; bus12.anim_en = 1'b0; bus12.pattern = 5'd0;
        bus12.hpos = '0; bus12.vpos = '0; bus12.hsize = 12'd640; bus12.vsize = 12'd480;
        bus12.color_in = '0;
        do_reset();

        // Solid colour on a 640-wide raster.
        frame(640, 480, 2, 16, 0, 'h2A, 1'b0, -1, -1);

        // Horizontal bright bars: boundaries of floor(7*x/640).
        frame(640, 480, 1, 8, 31, -1, 1'b0, -1, -1);
        for (int i = 0; i < 14; i++)
            check($sformatf("hbar_px%0d", cap_pos[i]), 12'(line_cap[cap_pos[i]]),
                  12'(bright_tab[cap_idx[i]]));

        // Scrolling checker, then every pattern with random frame strobes.
        anim = 1'b1;
        repeat (3) frame(40, 24, 6, 6, 4, -1, 1'b0, -1, -1);
        repeat (3) frame(40, 24, 24, 6, 32, -1, 1'b1, -1, -1);

        // Walk the counter to 254 so the next two frames run at 255 and then 0.
        while (m_f != 254) tick(1'b0, 0, 0, 1'b1, 0, 6'h0);
        repeat (2) frame(40, 12, 12, 6, 32, -1, 1'b0, -1, -1);

        // Sizes below 8 pin the bar index to 0.
        anim = 1'b0;
        frame(5, 4, 3, 4, 30, -1, 1'b0, -1, -1);
        for (int i = 0; i < 5; i++)
            check($sformatf("small_hbar_px%0d", i), 12'(line_cap[i]), 12'h02A);

        // Wide-colour instance: expansion and bar formatting.
        dir12(3, 12, 6'h15, 12'h00F);
        dir12(0, 31, 6'h15, 12'hFFF);
        dir12(1, 28, 6'h15, 12'h888);
        dir12(2, 19, 6'h15, 12'h00A);
        dir12(3, 0, 6'h2A, 12'hAAA);
        repeat (3) tick(1'b0, 0, 0, 1'b0, 0, 6'h0);

        // Reset in the middle of a line, then a clean frame of bars.
        anim = 1'b1;
        frame(40, 16, 6, 6, 33, -1, 1'b0, 2, 17);
        frame(40, 16, 16, 6, 33, -1, 1'b0, -1, -1);
        repeat (3) tick(1'b0, 0, 0, 1'b0, 0, 6'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
